// File: rtl/sw_ctrl_pkg.sv
// Shared constants and helpers for the switch run/clear front end.
//   Default parameter values for sw_run_ctrl / sw_debounce.
//   cnt_width(): counter width able to hold values 0..max_val (never narrower than 1 bit).
package sw_ctrl_pkg;

   localparam int unsigned DefNSw            = 2;
   localparam int unsigned DefDebounceCycles = 100000;
   localparam int unsigned DefTickDiv        = 1;
   localparam int unsigned DefRunIdx         = 0;
   localparam int unsigned DefClrIdx         = 1;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-switch conditioner: 2-flop synchroniser, stability counter, debounced level and
// registered one-cycle rise/fall flags that assert in the same cycle the level changes.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   sw    in   raw asynchronous switch input
//   level out  debounced level
//   rise  out  1-cycle pulse on debounced 0->1
//   fall  out  1-cycle pulse on debounced 1->0
module sw_debounce
   import sw_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync_q, syn_q;
   logic            stable_q, stable_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Counter only runs while the synced input disagrees with the accepted level; any
   // agreement restarts it, so short glitches never reach the output.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (syn_q != stable_q) begin
         if (cnt_q == CntLast) begin
            stable_d = syn_q;
            rise_d   = syn_q;
            fall_d   = ~syn_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 1'b0;
         syn_q    <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= sw;
         syn_q    <= sync_q;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level = stable_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/sw_run_ctrl.sv
// Run/clear front end for the timer datapath: debounces N_SW switches and derives a run
// enable, clear level/pulse and a divided tick clock-enable (no gated clocks).
// Optional feature macro: SW_CTRL_TOGGLE_EN -- run switch acts as a push-button that toggles
// the run state on each debounced rise; otherwise run follows the switch level.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sw         in   [N_SW] raw asynchronous switches
//   sw_level   out  [N_SW] debounced levels
//   sw_rise    out  [N_SW] 1-cycle debounced 0->1 pulses
//   sw_fall    out  [N_SW] 1-cycle debounced 1->0 pulses
//   run_en     out  timer run enable (clear dominates)
//   clr        out  clear level
//   clr_pulse  out  1-cycle pulse on clear assertion
//   tick       out  registered 1-cycle clock-enable for the timer core
module sw_run_ctrl
   import sw_ctrl_pkg::*;
#(
   parameter int unsigned N_SW            = DefNSw,
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned TICK_DIV        = DefTickDiv,
   parameter int unsigned RUN_IDX         = DefRunIdx,
   parameter int unsigned CLR_IDX         = DefClrIdx
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_SW-1:0] sw,
   output logic [N_SW-1:0] sw_level,
   output logic [N_SW-1:0] sw_rise,
   output logic [N_SW-1:0] sw_fall,
   output logic            run_en,
   output logic            clr,
   output logic            clr_pulse,
   output logic            tick
);

   localparam int unsigned     DivW    = cnt_width(TICK_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

   // Elaboration-time parameter checks.
   if (N_SW < 2) begin : g_err_nsw
      $error("sw_run_ctrl: N_SW must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_err_deb
      $error("sw_run_ctrl: DEBOUNCE_CYCLES must be >= 1");
   end
   if (TICK_DIV < 1) begin : g_err_div
      $error("sw_run_ctrl: TICK_DIV must be >= 1");
   end
   if (RUN_IDX >= N_SW || CLR_IDX >= N_SW) begin : g_err_idx
      $error("sw_run_ctrl: RUN_IDX/CLR_IDX out of range");
   end
   if (RUN_IDX == CLR_IDX) begin : g_err_same
      $error("sw_run_ctrl: RUN_IDX and CLR_IDX must differ");
   end

   for (genvar i = 0; i < int'(N_SW); i++) begin : g_deb
      sw_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk  (clk),
         .rst  (rst),
         .sw   (sw[i]),
         .level(sw_level[i]),
         .rise (sw_rise[i]),
         .fall (sw_fall[i])
      );
   end

   assign clr       = sw_level[CLR_IDX];
   assign clr_pulse = sw_rise[CLR_IDX];

   logic run_state;

`ifdef SW_CTRL_TOGGLE_EN
   logic run_state_q, run_state_d;

   // Clear both forces stop and masks start/stop presses while held.
   always_comb begin
      run_state_d = run_state_q;
      if (clr) begin
         run_state_d = 1'b0;
      end else if (sw_rise[RUN_IDX]) begin
         run_state_d = ~run_state_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_state_q <= 1'b0;
      end else begin
         run_state_q <= run_state_d;
      end
   end

   assign run_state = run_state_q;
`else
   assign run_state = sw_level[RUN_IDX];
`endif

   assign run_en = run_state & ~clr;

   // Tick divider: clear restarts the period, a stop just freezes it so a restart
   // resumes mid-period.
   logic [DivW-1:0] div_q, div_d;
   logic            tick_q, tick_d;

   always_comb begin
      div_d  = div_q;
      tick_d = 1'b0;
      if (clr) begin
         div_d = '0;
      end else if (run_en) begin
         tick_d = (div_q == DivLast);
         div_d  = tick_d ? '0 : div_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule
